// File: rtl/m_tick_prescaler_if.sv
// Tick prescaler bus: pacing controls in, tick pulse and status out.
// Handshake: none. w_run and w_div are levels, and w_step is edge-sensed.
// w_tick is a single-cycle registered pulse. It is meaningful on every
// cycle and needs no acknowledge.
interface m_tick_prescaler_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 2
);
    logic             w_run;
    logic             w_step;
    logic [DIV_W-1:0] w_div;
    logic             w_tick;
    logic [1:0]       w_state;
    logic [DIV_W-1:0] w_phase;
    logic [CNT_W-1:0] w_ticks;

    // Controller side: drives the pacing controls and observes the tick.
    modport master (
        output w_run, w_step, w_div,
        input  w_tick, w_state, w_phase, w_ticks
    );

    // Prescaler side.
    modport slave (
        input  w_run, w_step, w_div,
        output w_tick, w_state, w_phase, w_ticks
    );
endinterface

// File: rtl/m_tick_prescaler.sv
// Programmable clock prescaler. It issues a one-cycle w_tick every L cycles,
// either free-running (w_run level) or once per rising edge of w_step.
// The period is latched on entry and at each terminal count. A change on
// w_div therefore only affects the next period.
module m_tick_prescaler #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 2
) (
    input  logic                w_clock,
    input  logic                w_reset_n,
    m_tick_prescaler_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] l_lat_q, l_lat_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] ticks_q, ticks_d;
    logic             step_prev_q, step_prev_d;

    logic [DIV_W-1:0] div_eff;
    logic             step_rise;
    logic             terminal;

    // Period zero behaves as period one; a step request is a 0->1 edge.
    always_comb begin
        div_eff   = (bus.w_div == '0) ? DIV_W'(1) : bus.w_div;
        step_rise = bus.w_step & ~step_prev_q;
        terminal  = (phase_q == (l_lat_q - DIV_W'(1)));
    end

    // Next-state and datapath: phase counting, terminal action and mode changes.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        l_lat_d     = l_lat_q;
        tick_d      = 1'b0;
        ticks_d     = ticks_q;
        step_prev_d = bus.w_step;

        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                // A run request takes priority over a step request.
                if (bus.w_run) begin
                    state_d = ST_RUN;
                    l_lat_d = div_eff;
                end else if (step_rise) begin
                    state_d = ST_STEP;
                    l_lat_d = div_eff;
                end
            end

            ST_RUN: begin
                // Stopping wins even on the terminal cycle, so no tick is issued.
                if (!bus.w_run) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end else if (terminal) begin
                    tick_d  = 1'b1;
                    phase_d = '0;
                    ticks_d = ticks_q + CNT_W'(1);
                    l_lat_d = div_eff;
                end else begin
                    phase_d = phase_q + DIV_W'(1);
                end
            end

            ST_STEP: begin
                // Further step edges are dropped here. Raising w_run promotes
                // to RUN without restarting the current period.
                if (terminal) begin
                    tick_d  = 1'b1;
                    phase_d = '0;
                    ticks_d = ticks_q + CNT_W'(1);
                    l_lat_d = div_eff;
                    state_d = bus.w_run ? ST_RUN : ST_IDLE;
                end else begin
                    phase_d = phase_q + DIV_W'(1);
                    if (bus.w_run) begin
                        state_d = ST_RUN;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // State register with asynchronous clear of every output and the step-edge flop.
    always_ff @(posedge w_clock or negedge w_reset_n) begin
        if (!w_reset_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            l_lat_q     <= DIV_W'(1);
            tick_q      <= 1'b0;
            ticks_q     <= '0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            l_lat_q     <= l_lat_d;
            tick_q      <= tick_d;
            ticks_q     <= ticks_d;
            step_prev_q <= step_prev_d;
        end
    end

    assign bus.w_tick  = tick_q;
    assign bus.w_state = state_q;
    assign bus.w_phase = phase_q;
    assign bus.w_ticks = ticks_q;

endmodule

// File: tb/tb_m_tick_prescaler.sv
// Bench for m_tick_prescaler: a countdown reference model, directed scenarios
// and randomized run/step/div traffic.
module tb_m_tick_prescaler;
  localparam int DIV_W = 8;
  localparam int CNT_W = 2;
  localparam int OBS_W = 1 + 2 + DIV_W + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  m_tick_prescaler_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  m_tick_prescaler #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .w_clock  (clk),
    .w_reset_n(rst_n),
    .bus      (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [OBS_W-1:0] exp_q[$];
  logic [CNT_W-1:0] tick_exp_q[$];
  int checks = 0;
  int errors = 0;
  int tick_seen = 0;

  // ---------------- reference model ----------------
  // Mode 0 idle, 1 run, 2 step. The model counts cycles remaining until
  // the next tick. The phase is the number of cycles elapsed in the period.
  int m_mode = 0;
  int m_len = 1;
  int m_rem = 1;
  int m_count = 0;
  logic m_prev_step = 1'b0;

  function automatic int eff_len(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_len = 1;
    m_rem = 1;
    m_count = 0;
    m_prev_step = 1'b0;
  endtask

  task automatic model_edge(input logic run, input logic step, input int div, output logic tick);
    logic rise;
    rise = step && !m_prev_step;
    m_prev_step = step;
    tick = 1'b0;
    case (m_mode)
      0: begin
        if (run) begin
          m_mode = 1; m_len = eff_len(div); m_rem = m_len;
        end else if (rise) begin
          m_mode = 2; m_len = eff_len(div); m_rem = m_len;
        end
      end
      1: begin
        if (!run) begin
          m_mode = 0;
        end else begin
          m_rem--;
          if (m_rem == 0) begin
            tick = 1'b1;
            m_count = (m_count + 1) % (1 << CNT_W);
            m_len = eff_len(div); m_rem = m_len;
          end
        end
      end
      default: begin
        m_rem--;
        if (m_rem == 0) begin
          tick = 1'b1;
          m_count = (m_count + 1) % (1 << CNT_W);
          m_len = eff_len(div); m_rem = m_len;
          m_mode = run ? 1 : 0;
        end else if (run) begin
          m_mode = 1;
        end
      end
    endcase
  endtask

  // ---------------- check helper ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at the falling edge. The model predicts the outputs after
  // the next rising edge and queues them for the monitor.
  task automatic drive(input logic run, input logic step, input int div);
    logic tick;
    logic [DIV_W-1:0] ph;
    @(negedge clk);
    bus.w_run = run;
    bus.w_step = step;
    bus.w_div = DIV_W'(div);
    model_edge(run, step, div, tick);
    ph = (m_mode == 0) ? '0 : DIV_W'(m_len - m_rem);
    exp_q.push_back({tick, 2'(m_mode), ph, CNT_W'(m_count)});
    if (tick) tick_exp_q.push_back(CNT_W'(m_count));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tick"}, int'(bus.w_tick), 0);
    chk({tag, "_state"}, int'(bus.w_state), 0);
    chk({tag, "_phase"}, int'(bus.w_phase), 0);
    chk({tag, "_ticks"}, int'(bus.w_ticks), 0);
  endtask

  // Reset asserted between clock edges. Outputs must clear without a clock edge.
  task automatic mid_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.w_run = 1'b0;
    bus.w_step = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    exp_q.delete();
    tick_exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [OBS_W-1:0] e;
    logic [CNT_W-1:0] et;
    #1;
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.w_tick, bus.w_state, bus.w_phase, bus.w_ticks} !== e) begin
          errors++;
          $display("FAIL status @%0t: got tick=%0d state=%0d phase=%0d ticks=%0d expected tick=%0d state=%0d phase=%0d ticks=%0d",
                   $time, bus.w_tick, bus.w_state, bus.w_phase, bus.w_ticks,
                   e[OBS_W-1], e[OBS_W-2 -: 2], e[CNT_W +: DIV_W], e[CNT_W-1:0]);
        end
      end
      if (bus.w_tick) begin
        tick_seen++;
        checks++;
        if (tick_exp_q.size() == 0) begin
          errors++;
          $display("FAIL tick_event @%0t: got unexpected tick (ticks=%0d) expected none", $time, bus.w_ticks);
        end else begin
          et = tick_exp_q.pop_front();
          if (bus.w_ticks !== et) begin
            errors++;
            $display("FAIL tick_count @%0t: got %0d expected %0d", $time, bus.w_ticks, et);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    logic run_r;
    bus.w_run = 1'b0;
    bus.w_step = 1'b0;
    bus.w_div = '0;

    // Reset state while the reset input is low from time zero.
    #2;
    check_reset_outputs("por");
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // 1: div=4 free run, ticks wrap 1,2,3,0.
    for (int i = 0; i < 17; i++) drive(1'b1, 1'b0, 4);
    idle(3);

    // 2: div=0 and div=1 tick every cycle with phase held at 0.
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1);
    idle(3);

    // 3: a held step gives one tick. A fresh 0->1 edge gives another.
    base = tick_seen;
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 3);
    idle(3);
    chk("step_held_one_tick", tick_seen - base, 1);
    drive(1'b0, 1'b1, 3);
    idle(5);
    chk("step_second_edge", tick_seen - base, 2);

    // 4: period change mid-period takes effect at the next reload.
    drive(1'b1, 1'b0, 4);
    drive(1'b1, 1'b0, 4);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 2);
    idle(3);

    // 5: stop on the terminal cycle suppresses the tick.
    base = tick_seen;
    drive(1'b1, 1'b0, 3);
    drive(1'b1, 1'b0, 3);
    drive(1'b1, 1'b0, 3);
    drive(1'b0, 1'b0, 3);
    idle(3);
    chk("stop_on_terminal_no_tick", tick_seen - base, 0);

    // 6: asynchronous reset mid-run, then silence with run low.
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 5);
    mid_reset("mid");
    base = tick_seen;
    idle(20);
    chk("no_tick_after_reset", tick_seen - base, 0);

    // Randomized traffic: run toggles rarely, step is bursty, short periods.
    run_r = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 15) == 0) run_r = ~run_r;
      drive(run_r, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 6)));
      if (i == 350) begin
        mid_reset("rnd");
        run_r = 1'b0;
      end
    end
    idle(3);

    @(posedge clk);
    #3;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("tick_q_drained", tick_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
